// File: rtl/adder.sv
`timescale 1ns/1ps
// Sequential IEEE-754-style adder (IDLE -> ALIGN -> ADD -> NORM -> DONE), truncating by default.
// Optional feature macro ADDER_ROUND_NEAREST_EN keeps guard/round/sticky bits and rounds to nearest even.
module adder #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic                                 load,
    input  logic [Mantissa_Size+Exponent_Size:0] A,
    input  logic [Mantissa_Size+Exponent_Size:0] B,
    output logic [Mantissa_Size+Exponent_Size:0] result,
    output logic                                 done,
    output logic                                 zero_flag,
    output logic                                 overflow,
    output logic                                 underflow,
    output logic                                 NAN
);
    localparam int M   = Mantissa_Size;
    localparam int E   = Exponent_Size;
    localparam int W   = M + E + 1;
`ifdef ADDER_ROUND_NEAREST_EN
    localparam int GRS = 3;
`else
    localparam int GRS = 0;
`endif
    localparam int MW  = M + 1 + GRS;
    localparam int EW  = E + 2;
    localparam int LZW = $clog2(MW + 1);
    localparam logic [E-1:0]        EXP_ONES = '1;
    localparam logic signed [EW-1:0] EXP_MAX = EW'(EXP_ONES);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t                state;
    logic [W-1:0]          a_q, b_q;
    logic                  sx_p0, sub_p0;
    logic [E-1:0]          ex_p0;
    logic [MW-1:0]         mx_p0, my_p0;
    logic                  sx_p1;
    logic [E-1:0]          ex_p1;
    logic [MW:0]           sum_p1;
    logic                  sx_p2;
    logic signed [EW-1:0]  exp_p2;
    logic [MW-1:0]         mant_p2;

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        lzc = LZW'(MW);
        for (int i = 0; i < MW; i++)
            if (v[i]) lzc = LZW'(MW - 1 - i);
    endfunction

`ifdef ADDER_ROUND_NEAREST_EN
    function automatic logic [M+1:0] round_mant(input logic [MW-1:0] m);
        logic [M:0] keep;
        logic       up;
        keep = m[MW-1:GRS];
        up   = m[GRS-1] & ((|m[GRS-2:0]) | keep[0]);
        return {1'b0, keep} + (M+2)'(up);
    endfunction
`else
    function automatic logic [M+1:0] round_mant(input logic [MW-1:0] m);
        return {1'b0, m};
    endfunction
`endif

    // ALIGN: larger magnitude becomes X, smaller is shifted right by the exponent gap
    logic          a_big, x_sign;
    logic [E-1:0]  x_exp, y_exp, shamt;
    logic [M-1:0]  x_frac, y_frac;
    logic [MW-1:0] mx_full, my_full, my_sh;

    always_comb begin
        a_big   = a_q[W-2:0] >= b_q[W-2:0];
        x_sign  = a_big ? a_q[W-1]   : b_q[W-1];
        x_exp   = a_big ? a_q[W-2:M] : b_q[W-2:M];
        x_frac  = a_big ? a_q[M-1:0] : b_q[M-1:0];
        y_exp   = a_big ? b_q[W-2:M] : a_q[W-2:M];
        y_frac  = a_big ? b_q[M-1:0] : a_q[M-1:0];
        shamt   = x_exp - y_exp;
        mx_full = MW'({|x_exp, x_frac}) << GRS;
        my_full = MW'({|y_exp, y_frac}) << GRS;
        my_sh   = my_full >> shamt;
`ifdef ADDER_ROUND_NEAREST_EN
        my_sh[0] = my_sh[0] | ((my_sh << shamt) != my_full);
`endif
    end

    // ADD: magnitude sum or difference, one carry bit of headroom
    logic [MW:0] sum_c;

    always_comb begin
        if (sub_p0) sum_c = {1'b0, mx_p0} - {1'b0, my_p0};
        else        sum_c = {1'b0, mx_p0} + {1'b0, my_p0};
    end

    // NORM: single-cycle barrel normalisation
    logic [LZW-1:0]       lz;
    logic [MW-1:0]        mant_c;
    logic signed [EW-1:0] exp_c;

    always_comb begin
        lz = lzc(sum_p1[MW-1:0]);
        if (sum_p1[MW]) begin
            mant_c = sum_p1[MW:1];
`ifdef ADDER_ROUND_NEAREST_EN
            mant_c[0] = mant_c[0] | sum_p1[0];
`endif
            exp_c  = $signed(EW'(ex_p1) + EW'(1));
        end else begin
            mant_c = sum_p1[MW-1:0] << lz;
            exp_c  = $signed(EW'(ex_p1) - EW'(lz));
        end
    end

    // DONE: special operands take priority over the arithmetic path
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [M+1:0]         rnd;
    logic signed [EW-1:0] r_exp;
    logic [M-1:0]         r_frac;
    logic [W-1:0]         fin_res;
    logic                 fin_zero, fin_ovf, fin_unf, fin_nan;

    always_comb begin
        a_nan    = (a_q[W-2:M] == EXP_ONES) && (a_q[M-1:0] != '0);
        b_nan    = (b_q[W-2:M] == EXP_ONES) && (b_q[M-1:0] != '0);
        a_inf    = (a_q[W-2:M] == EXP_ONES) && (a_q[M-1:0] == '0);
        b_inf    = (b_q[W-2:M] == EXP_ONES) && (b_q[M-1:0] == '0);
        a_zero   = a_q[W-2:M] == '0;
        b_zero   = b_q[W-2:M] == '0;
        rnd      = round_mant(mant_p2);
        r_exp    = exp_p2 + $signed(EW'(rnd[M+1]));
        r_frac   = rnd[M+1] ? rnd[M:1] : rnd[M-1:0];
        fin_res  = '0;
        fin_zero = 1'b0;
        fin_ovf  = 1'b0;
        fin_unf  = 1'b0;
        fin_nan  = 1'b0;
        if (a_nan) begin
            fin_res        = a_q;
            fin_res[M-1]   = 1'b1;
            fin_nan        = 1'b1;
        end else if (b_nan) begin
            fin_res        = b_q;
            fin_res[M-1]   = 1'b1;
            fin_nan        = 1'b1;
        end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
            fin_res[W-2:M] = EXP_ONES;
            fin_res[M-1]   = 1'b1;
            fin_nan        = 1'b1;
        end else if (a_inf) begin
            fin_res = a_q;
        end else if (b_inf) begin
            fin_res = b_q;
        end else if (a_zero) begin
            fin_res  = b_q;
            fin_zero = b_q[W-2:0] == '0;
        end else if (b_zero) begin
            fin_res  = a_q;
            fin_zero = a_q[W-2:0] == '0;
        end else if (!mant_p2[MW-1]) begin
            fin_zero = 1'b1;
        end else if (exp_p2 < EXP_ONE) begin
            fin_zero = 1'b1;
            fin_unf  = 1'b1;
        end else if (r_exp >= EXP_MAX) begin
            fin_res  = {sx_p2, EXP_ONES, {M{1'b0}}};
            fin_ovf  = 1'b1;
        end else begin
            fin_res  = {sx_p2, r_exp[E-1:0], r_frac};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sx_p0     <= 1'b0;
            sub_p0    <= 1'b0;
            ex_p0     <= '0;
            mx_p0     <= '0;
            my_p0     <= '0;
            sx_p1     <= 1'b0;
            ex_p1     <= '0;
            sum_p1    <= '0;
            sx_p2     <= 1'b0;
            exp_p2    <= '0;
            mant_p2   <= '0;
            result    <= '0;
            done      <= 1'b0;
            zero_flag <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            NAN       <= 1'b0;
        end else if (enable) begin
            if (load) begin
                a_q       <= A;
                b_q       <= B;
                state     <= ALIGN;
                result    <= '0;
                done      <= 1'b0;
                zero_flag <= 1'b0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                NAN       <= 1'b0;
            end else begin
                case (state)
                    ALIGN: begin
                        sx_p0  <= x_sign;
                        sub_p0 <= a_q[W-1] != b_q[W-1];
                        ex_p0  <= x_exp;
                        mx_p0  <= mx_full;
                        my_p0  <= my_sh;
                        state  <= ADD;
                    end
                    ADD: begin
                        sx_p1  <= sx_p0;
                        ex_p1  <= ex_p0;
                        sum_p1 <= sum_c;
                        state  <= NORM;
                    end
                    NORM: begin
                        sx_p2   <= sx_p1;
                        exp_p2  <= exp_c;
                        mant_p2 <= mant_c;
                        state   <= DONE;
                    end
                    DONE: begin
                        result    <= fin_res;
                        zero_flag <= fin_zero;
                        overflow  <= fin_ovf;
                        underflow <= fin_unf;
                        NAN       <= fin_nan;
                        done      <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
`timescale 1ns/1ps
// Self-checking bench for adder (E=8, M=23, truncation): directed corner cases plus
// randomized operands compared against an integer-arithmetic reference model.
module tb_adder;
    logic        clk = 1'b0;
    logic        rst, enable, load;
    logic [31:0] A, B, result;
    logic        done, zero_flag, overflow, underflow, NAN;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] got_res;
    logic [3:0]  got_flg;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;   // {NAN, overflow, underflow, zero_flag}
    } ref_t;

    adder #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .A(A), .B(B),
        .result(result), .done(done), .zero_flag(zero_flag), .overflow(overflow),
        .underflow(underflow), .NAN(NAN)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] flags();
        return {NAN, overflow, underflow, zero_flag};
    endfunction

    // Reference: value-level float addition with truncating alignment and normalisation
    function automatic ref_t ref_add(input logic [31:0] a, input logic [31:0] b);
        ref_t   r;
        int     ea, eb, ex, ey, d, e;
        longint mx, my, s;
        logic   sx, a_big;
        logic [7:0] e8;
        r  = '0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 && a[22:0] != 0) begin r.res = a | 32'h0040_0000; r.flg = 4'b1000; return r; end
        if (eb == 255 && b[22:0] != 0) begin r.res = b | 32'h0040_0000; r.flg = 4'b1000; return r; end
        if (ea == 255 && eb == 255 && a[31] != b[31]) begin r.res = 32'h7FC0_0000; r.flg = 4'b1000; return r; end
        if (ea == 255) begin r.res = a; return r; end
        if (eb == 255) begin r.res = b; return r; end
        if (ea == 0) begin r.res = b; r.flg = (b[30:0] == 0) ? 4'b0001 : 4'b0000; return r; end
        if (eb == 0) begin r.res = a; return r; end
        a_big = (ea > eb) || (ea == eb && a[22:0] >= b[22:0]);
        sx = a_big ? a[31] : b[31];
        ex = a_big ? ea : eb;
        ey = a_big ? eb : ea;
        mx = (longint'(1) << 23) + longint'(a_big ? a[22:0] : b[22:0]);
        my = (longint'(1) << 23) + longint'(a_big ? b[22:0] : a[22:0]);
        d  = ex - ey;
        my = (d >= 40) ? 0 : my / (longint'(1) << d);
        s  = (a[31] == b[31]) ? mx + my : mx - my;
        if (s == 0) begin r.flg = 4'b0001; return r; end
        e = ex;
        while (s >= (longint'(1) << 24)) begin s = s / 2; e++; end
        while (s <  (longint'(1) << 23)) begin s = s * 2; e--; end
        if (e <= 0) begin r.flg = 4'b0011; return r; end
        if (e >= 255) begin r.res = {sx, 8'hFF, 23'h0}; r.flg = 4'b0100; return r; end
        e8 = 8'(e);
        r.res = {sx, e8, s[22:0]};
        return r;
    endfunction

    task automatic run_edges(input bit stall, input int target, inout int n);
        for (int cyc = 0; cyc < 64 && n < target; cyc++) begin
            enable = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (enable) n++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit stall, input string tag);
        ref_t r;
        int   n;
        r = ref_add(a, b);
        @(negedge clk);
        A = a; B = b; load = 1'b1; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check({tag, "_clr_res"}, result, 32'h0);
        check({tag, "_clr_ctl"}, 32'({done, flags()}), 32'h0);
        n = 0;
        run_edges(stall, 3, n);
        check({tag, "_early"}, 32'(done), 32'h0);
        run_edges(stall, 4, n);
        check({tag, "_edges"}, n, 32'd4);
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_res"}, result, r.res);
        check({tag, "_flg"}, 32'(flags()), 32'(r.flg));
        got_res = result;
        got_flg = flags();
        enable  = 1'b1;
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1; enable = 1'b0; load = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("rst_res", result, 32'h0);
        check("rst_ctl", 32'({done, flags()}), 32'h0);
        rst = 1'b0;

        do_op(32'h4000_0000, 32'h4000_0000, 1'b0, "r032");
        check("r032_k", got_res, 32'h4080_0000);
        do_op(32'h7F00_0000, {1'b0, 8'hFC, 23'h7E3B78}, 1'b0, "r033a");
        do_op(32'h7F00_0000, {1'b0, 8'hFD, 23'h000002}, 1'b0, "r033b");
        check("r033b_k", got_res, 32'h7F40_0001);
        do_op({1'b0, 8'hFE, 23'h7FFFFF}, {1'b0, 8'hFE, 23'h000001}, 1'b0, "r034");
        check("r034_k", got_res, 32'h7F80_0000);
        check("r034_kf", 32'(got_flg), 32'h4);
        do_op({1'b0, 8'hFE, 23'h7}, {1'b1, 8'hFE, 23'h7}, 1'b0, "r035a");
        check("r035a_kf", 32'(got_flg), 32'h1);
        do_op({1'b0, 8'hFD, 23'hF}, {1'b1, 8'hFE, 23'h7}, 1'b0, "r035b");
        check("r035b_k", got_res, 32'hFE80_0000);
        do_op({1'b0, 8'h01, 23'hF}, {1'b1, 8'h01, 23'h7}, 1'b0, "r036");
        check("r036_kf", 32'(got_flg), 32'h3);
        do_op({1'b0, 8'hFF, 23'h400000}, {1'b1, 8'h01, 23'h7}, 1'b0, "r037");
        check("r037_k", got_res, 32'h7FC0_0000);
        check("r037_kf", 32'(got_flg), 32'h8);
        do_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, "infinf");
        check("infinf_k", got_res, 32'h7FC0_0000);
        do_op(32'hFF80_0000, 32'h3F80_0000, 1'b0, "inffin");
        do_op(32'h0000_0000, 32'hC049_0FDB, 1'b0, "zeroa");
        check("zeroa_k", got_res, 32'hC049_0FDB);

        // enable low freezes everything, including load
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, "hold");
        @(negedge clk);
        enable = 1'b0; load = 1'b1; A = 32'h1234_5678; B = 32'h4000_0000;
        repeat (3) @(negedge clk);
        check("hold_res", result, 32'h4000_0000);
        check("hold_done", 32'(done), 32'h1);
        load = 1'b0; enable = 1'b1;

        // new load mid-operation restarts with the new operands
        @(negedge clk);
        A = 32'h4000_0000; B = 32'h4000_0000; load = 1'b1; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, "restart");
        check("restart_k", got_res, 32'h4040_0000);

        // asynchronous reset clears finished outputs without a clock edge
        rst = 1'b1;
        #1;
        check("arst_res", result, 32'h0);
        check("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-operation abandons it
        A = 32'h4000_0000; B = 32'h3F80_0000; load = 1'b1; enable = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rstmid_done", 32'(done), 32'h0);
        check("rstmid_res", result, 32'h0);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 11))
                0: a[30:23] = 8'hFF;
                1: a[30:23] = 8'h00;
                2: a[30:23] = 8'hFE;
                3: a[30:23] = 8'h01;
                default: ;
            endcase
            case ($urandom_range(0, 11))
                0: b[30:23] = 8'hFF;
                1: b[30:23] = 8'h00;
                2: if ($urandom_range(0, 1) == 1) b[22:0] = 23'h0;
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: b[30:23] = a[30:23] + 8'($urandom_range(0, 3));
                1: begin b = a ^ 32'h8000_0000; b[3:0] = 4'($urandom); end
                default: ;
            endcase
            do_op(a, b, $urandom_range(0, 1) == 1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
